// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction-fetch front end. Fetches sequential words from instruction
//   memory over a req/gnt + rvalid interface (variable latency, in-order
//   responses). Returned words are queued with their PC in a DEPTH-entry FIFO
//   and handed downstream through a valid/ready handshake. A redirect flushes
//   the queue, restarts fetching at the new target and discards any responses
//   that are still in flight.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous reset, active low
//   redirect_valid  branch/jump taken this cycle
//   redirect_pc     new fetch target (bits [1:0] ignored)
//   imem_req        fetch request
//   imem_addr       word-aligned fetch address
//   imem_gnt        request accepted (meaningful only while imem_req=1)
//   imem_rvalid     read data valid, one per granted request, in order
//   imem_rdata      instruction word
//   if_valid        instruction available at queue head
//   if_pc           PC of head instruction (0 when empty)
//   if_instr        head instruction word (0 when empty)
//   if_ready        downstream consumes the head when if_valid=1
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0]   CAPACITY = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];

   logic [31:0]   redirect_target;
   logic [CW:0]   in_use;
   logic          handshake;
   logic          push;
   logic          pop;
   logic [CW-1:0] outstanding_dec;

   // Masking (rather than slicing) keeps every redirect_pc bit referenced.
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   // Credit rule: queued words plus fetches in flight never exceed DEPTH, so
   // every response is guaranteed a free FIFO slot.
   assign in_use    = {1'b0, count} + {1'b0, outstanding};
   assign imem_req  = reset && !redirect_valid && (in_use < CAPACITY);
   assign imem_addr = fetch_pc;
   assign handshake = imem_req && imem_gnt;

   // Outstanding count after this cycle's response has retired.
   assign outstanding_dec = outstanding - (imem_rvalid ? CNT_ONE : '0);

   // Responses belonging to a flushed fetch stream are counted off by drop.
   assign push = imem_rvalid && (drop == '0) && !redirect_valid;
   assign pop  = if_valid && if_ready && !redirect_valid;

   assign if_valid = (count != '0);
   assign if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
   assign if_instr = if_valid ? instr_mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect_valid) begin
         // Everything still in flight belongs to the old stream; any earlier
         // pending drop is part of outstanding and is therefore subsumed.
         fetch_pc    <= redirect_target;
         rsp_pc      <= redirect_target;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= outstanding_dec;
         drop        <= outstanding_dec;
      end else begin
         if (handshake) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         outstanding <= outstanding_dec + (handshake ? CNT_ONE : '0);
         if (imem_rvalid && (drop != '0)) begin
            drop <= drop - CNT_ONE;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            rsp_pc <= rsp_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage has no reset; reads are gated by count, so stale
   // contents are never visible and the array can map to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= rsp_pc;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

   // A response with nothing in flight means the memory broke protocol.
   rvalid_has_request: assert property (
      @(posedge clk) disable iff (!reset) imem_rvalid |-> (outstanding != '0));

endmodule
